// File: rtl/writeback_queue.sv
// writeback_queue: in-order FIFO of pending register-file writebacks with per-register pending flags.
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   inValid/inReady   producer handshake; inIsVec, inReg, inData describe the result offered
//   flush, hold       flush empties the queue at the next edge; hold pauses draining only
//   regWrEnSc/Vec     write strobes for the head entry; regToWrite and dataIn carry its index and data
//   pendingSc/Vec     one flag per register with a queued write of that kind
//   count             number of occupied entries
module writeback_queue #(
   parameter int registerSize  = 8,
   parameter int vecSize       = 16,
   parameter int selectionBits = 4,
   parameter int DEPTH         = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              inValid,
   output logic                              inReady,
   input  logic                              inIsVec,
   input  logic [selectionBits-1:0]          inReg,
   input  logic [vecSize*registerSize-1:0]   inData,
   input  logic                              flush,
   input  logic                              hold,
   output logic                              regWrEnSc,
   output logic                              regWrEnVec,
   output logic [selectionBits-1:0]          regToWrite,
   output logic [vecSize*registerSize-1:0]   dataIn,
   output logic [(1<<selectionBits)-1:0]     pendingSc,
   output logic [(1<<selectionBits)-1:0]     pendingVec,
   output logic [$clog2(DEPTH):0]            count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [DEPTH-1:0] valid;
   logic ent_vec [DEPTH];
   logic [selectionBits-1:0] ent_reg [DEPTH];
   logic [vecSize*registerSize-1:0] ent_data [DEPTH];
   logic enq, deq;
   assign inReady = (count != FULL) && !flush;
   assign enq = inValid && inReady;
   assign deq = (count != '0) && !hold && !flush;
   assign regWrEnSc = deq && !ent_vec[rd_ptr];
   assign regWrEnVec = deq && ent_vec[rd_ptr];
   assign regToWrite = deq ? ent_reg[rd_ptr] : '0;
   assign dataIn = deq ? ent_data[rd_ptr] : '0;
   always_comb begin
      pendingSc = '0;
      pendingVec = '0;
      for (int i = 0; i < DEPTH; i++)
         if (valid[i]) begin
            if (ent_vec[i]) pendingVec[ent_reg[i]] = 1'b1;
            else pendingSc[ent_reg[i]] = 1'b1;
         end
   end
   // Control state; enqueue and dequeue never touch the same slot since 0 < count < DEPTH when both fire.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         valid <= '0;
         count <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         valid <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + 1'b1;
            valid[wr_ptr] <= 1'b1;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
            valid[rd_ptr] <= 1'b0;
         end
         count <= count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, deq};
      end
   // Payload storage is qualified by valid/count, so it carries no reset.
   always_ff @(posedge clk)
      if (enq) begin
         ent_vec[wr_ptr] <= inIsVec;
         ent_reg[wr_ptr] <= inReg;
         ent_data[wr_ptr] <= inData;
      end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed stimulus with a queue-based reference model checked every cycle.
module tb_writeback_queue;
   logic clk = 0, reset = 0, inValid = 0, inIsVec = 0, flush = 0, hold = 0;
   logic [3:0] inReg = 0;
   logic [127:0] inData = 0;
   logic inReady, regWrEnSc, regWrEnVec;
   logic [3:0] regToWrite;
   logic [127:0] dataIn;
   logic [15:0] pendingSc, pendingVec;
   logic [2:0] count;
   int checks = 0, errors = 0;
   bit run = 0;
   typedef struct {bit vec; logic [3:0] r; logic [127:0] d;} ent_t;
   ent_t mq[$];
   logic [3:0] commits[$];
   logic [15:0] exp_ps, exp_pv;
   bit exp_deq;

   writeback_queue dut (.clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
      .inIsVec(inIsVec), .inReg(inReg), .inData(inData), .flush(flush), .hold(hold),
      .regWrEnSc(regWrEnSc), .regWrEnVec(regWrEnVec), .regToWrite(regToWrite), .dataIn(dataIn),
      .pendingSc(pendingSc), .pendingVec(pendingVec), .count(count));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
   endtask

   always @(negedge reset) mq.delete();

   always @(posedge clk) begin
      if (!reset) mq.delete();
      else if (flush) mq.delete();
      else begin
         automatic bit d = mq.size() > 0 && !hold;
         automatic bit e = inValid && mq.size() < 4;
         if (d) void'(mq.pop_front());
         if (e) mq.push_back('{inIsVec, inReg, inData});
      end
   end

   always @(negedge clk) begin
      if (regWrEnSc || regWrEnVec) commits.push_back(regToWrite);
      if (run) begin
         exp_ps = '0;
         exp_pv = '0;
         foreach (mq[i]) if (mq[i].vec) exp_pv[mq[i].r] = 1'b1; else exp_ps[mq[i].r] = 1'b1;
         exp_deq = mq.size() > 0 && !hold && !flush;
         chk("m_count", count, mq.size());
         chk("m_inReady", inReady, mq.size() < 4 && !flush);
         chk("m_wrEnSc", regWrEnSc, exp_deq && !mq[0].vec);
         chk("m_wrEnVec", regWrEnVec, exp_deq && mq[0].vec);
         chk("m_regToWrite", regToWrite, exp_deq ? mq[0].r : 4'h0);
         chk("m_dataIn", dataIn, exp_deq ? mq[0].d : 128'h0);
         chk("m_pendingSc", pendingSc, exp_ps);
         chk("m_pendingVec", pendingVec, exp_pv);
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit v, input bit vec, input logic [3:0] r, input logic [127:0] d, input bit fl, input bit h);
      inValid = v; inIsVec = vec; inReg = r; inData = d; flush = fl; hold = h;
   endtask

   initial begin
      tick; tick;
      reset = 1;
      run = 1;
      #1;
      chk("rst_inReady", inReady, 1);
      chk("rst_count", count, 0);
      chk("rst_strobes", {regWrEnSc, regWrEnVec}, 0);
      chk("rst_pending", {pendingSc, pendingVec}, 0);
      // single scalar
      drive(1, 0, 3, 128'hA5, 0, 0); tick;
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("sc_wrEnSc", regWrEnSc, 1);
      chk("sc_wrEnVec", regWrEnVec, 0);
      chk("sc_reg", regToWrite, 3);
      chk("sc_data0", dataIn[7:0], 8'hA5);
      chk("sc_pend", pendingSc, 16'h0008);
      tick; #1;
      chk("sc_pend_after", pendingSc, 0);
      chk("sc_count_after", count, 0);
      // fill under hold, then drain in order
      for (int i = 0; i < 4; i++) begin drive(1, 1, 4'(i), {16{8'(8'h30 + i)}}, 0, 1); tick; end
      drive(0, 0, 0, 0, 0, 1); #1;
      chk("hold_count", count, 4);
      chk("hold_inReady", inReady, 0);
      chk("hold_strobes", {regWrEnSc, regWrEnVec}, 0);
      chk("hold_pendVec", pendingVec, 16'h000F);
      hold = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_wrEnVec", regWrEnVec, 1);
         chk("drain_reg", regToWrite, i);
         tick;
      end
      #1 chk("drain_count", count, 0);
      // full with simultaneous traffic and wrap-around
      commits.delete();
      for (int i = 0; i < 4; i++) begin drive(1, 0, 4'(i), 128'(i * 17), 0, 1); tick; end
      drive(1, 0, 4, 128'(4 * 17), 0, 0); #1;
      chk("full_inReady", inReady, 0);
      chk("full_count", count, 4);
      tick; #1;
      chk("full_count_after", count, 3);
      chk("full_head", regToWrite, 1);
      for (int i = 4; i < 10; i++) begin
         drive(1, 0, 4'(i), 128'(i * 17), 0, 0); #1;
         chk("wrap_inReady", inReady, 1);
         tick; #1;
         chk("wrap_count", count, 3);
      end
      drive(0, 0, 0, 0, 0, 0);
      tick; tick; tick; #1;
      chk("wrap_drained", count, 0);
      chk("wrap_ncommits", commits.size(), 10);
      for (int i = 0; i < 10; i++) chk("wrap_order", commits[i], i);
      // same-register ordering
      drive(1, 0, 5, 128'h11, 0, 1); tick;
      drive(1, 0, 5, 128'h22, 0, 1); tick;
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("same_first", dataIn[7:0], 8'h11);
      chk("same_pend1", pendingSc, 16'h0020);
      tick; #1;
      chk("same_second", dataIn[7:0], 8'h22);
      chk("same_pend2", pendingSc, 16'h0020);
      tick; #1;
      chk("same_pend3", pendingSc, 0);
      // flush with offer
      for (int i = 0; i < 3; i++) begin drive(1, i[0], 4'(i + 8), 128'(i), 0, 1); tick; end
      drive(1, 0, 12, 128'hEE, 1, 0); #1;
      chk("fl_strobes", {regWrEnSc, regWrEnVec}, 0);
      chk("fl_inReady", inReady, 0);
      chk("fl_count", count, 3);
      tick;
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("fl_count_after", count, 0);
      chk("fl_pending", {pendingSc, pendingVec}, 0);
      // async reset mid-operation
      for (int i = 0; i < 2; i++) begin drive(1, 0, 4'(i + 1), 128'hC0, 0, 1); tick; end
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("ar_count_pre", count, 2);
      reset = 0; #1;
      chk("ar_count", count, 0);
      chk("ar_inReady", inReady, 1);
      chk("ar_strobes", {regWrEnSc, regWrEnVec}, 0);
      chk("ar_outs", {regToWrite, dataIn}, 0);
      chk("ar_pending", {pendingSc, pendingVec}, 0);
      tick;
      reset = 1;
      tick; tick; #1;
      chk("ar_quiet_count", count, 0);
      chk("ar_quiet_strobes", {regWrEnSc, regWrEnVec}, 0);
      drive(1, 1, 9, {16{8'h5A}}, 0, 0); tick;
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("ar_new_wrEnVec", regWrEnVec, 1);
      chk("ar_new_reg", regToWrite, 9);
      tick; tick;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
